// File: rtl/i2c_slave_regif.sv
// I2C target with an 8-bit auto-incrementing register pointer and a one-Clk
// strobe register port. All bus sensing runs on Clk-synchronized copies of SCL/SDA.
module i2c_slave_regif #(
   parameter logic [6:0] DEV_ADDR = 7'h10
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       i2c_sclk,
   inout  wire        i2c_sdat,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wrdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rddata,
   output logic       busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK
   } state_t;

   logic       scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_prev_q, scl_prev_d;
   logic       sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_prev_q, sda_prev_d;
   logic [2:0] settle_q, settle_d;
   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] tx_q, tx_d;
   logic       rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] reg_addr_q, reg_addr_d;
   logic [7:0] reg_wrdata_q, reg_wrdata_d;
   logic       reg_wr_q, reg_wr_d;
   logic       reg_rd_q, reg_rd_d;
   logic       busy_q, busy_d;

   logic settled, scl_rise, scl_fall, start_det, stop_det;

   // After reset the sync chain holds idle-high guesses; suppress edge detection
   // until the real bus level has propagated all the way to the _prev stage.
   assign settled   = settle_q[2];
   assign scl_rise  = settled &  scl_sync_q & ~scl_prev_q;
   assign scl_fall  = settled & ~scl_sync_q &  scl_prev_q;
   assign start_det = settled & scl_sync_q & scl_prev_q &  sda_prev_q & ~sda_sync_q;
   assign stop_det  = settled & scl_sync_q & scl_prev_q & ~sda_prev_q &  sda_sync_q;

   always_comb begin
      scl_meta_d   = i2c_sclk;
      scl_sync_d   = scl_meta_q;
      scl_prev_d   = scl_sync_q;
      sda_meta_d   = i2c_sdat;
      sda_sync_d   = sda_meta_q;
      sda_prev_d   = sda_sync_q;
      settle_d     = {settle_q[1:0], 1'b1};
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      tx_d         = tx_q;
      rw_d         = rw_q;
      sda_oe_d     = sda_oe_q;
      reg_addr_d   = reg_addr_q;
      reg_wrdata_d = reg_wrdata_q;
      reg_wr_d     = 1'b0;
      reg_rd_d     = 1'b0;
      busy_d       = busy_q;

      // Read data is captured exactly one Clk after the read strobe.
      if (reg_rd_q) tx_d = reg_rddata;

      if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               bit_cnt_d = 4'd0;
            end

            ADDR: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = {shift_q[6:0], sda_sync_q};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = 4'd0;
                  if (shift_q[7:1] == DEV_ADDR) begin
                     state_d  = ADDR_ACK;
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                     rw_d     = shift_q[0];
                     // Fetch the first read byte now so bit 7 is ready when the ACK ends.
                     reg_rd_d = shift_q[0];
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end

            PTR: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = {shift_q[6:0], sda_sync_q};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d  = 4'd0;
                  reg_addr_d = shift_q;
                  state_d    = PTR_ACK;
                  sda_oe_d   = 1'b1;
               end
            end

            WDATA: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = {shift_q[6:0], sda_sync_q};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d    = 4'd0;
                  reg_wrdata_d = shift_q;
                  reg_wr_d     = 1'b1;
                  state_d      = WDATA_ACK;
                  sda_oe_d     = 1'b1;
               end
            end

            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_rise) begin
                  bit_cnt_d = 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = 1'b0;
                  if (state_q == ADDR_ACK) begin
                     if (rw_q) begin
                        state_d  = RDATA;
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                     end else begin
                        state_d = PTR;
                     end
                  end else if (state_q == PTR_ACK) begin
                     state_d = WDATA;
                  end else begin
                     state_d    = WDATA;
                     reg_addr_d = reg_addr_q + 8'd1;
                  end
               end
            end

            RDATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d  = 4'd0;
                  sda_oe_d   = 1'b0;
                  state_d    = MACK;
                  reg_addr_d = reg_addr_q + 8'd1;
               end else if (scl_fall && bit_cnt_q != 4'd0) begin
                  sda_oe_d = ~tx_q[7];
                  tx_d     = {tx_q[6:0], 1'b0};
               end
            end

            MACK: begin
               if (scl_rise) begin
                  if (sda_sync_q) begin
                     state_d   = IDLE;
                     busy_d    = 1'b0;
                     bit_cnt_d = 4'd0;
                  end else begin
                     // Master wants another byte: fetch it before the falling edge.
                     bit_cnt_d = 4'd1;
                     reg_rd_d  = 1'b1;
                  end
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  bit_cnt_d = 4'd0;
                  state_d   = RDATA;
                  sda_oe_d  = ~tx_q[7];
                  tx_d      = {tx_q[6:0], 1'b0};
               end
            end

            default: begin
               state_d   = IDLE;
               bit_cnt_d = 4'd0;
               sda_oe_d  = 1'b0;
               busy_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         scl_meta_q   <= 1'b1;
         scl_sync_q   <= 1'b1;
         scl_prev_q   <= 1'b1;
         sda_meta_q   <= 1'b1;
         sda_sync_q   <= 1'b1;
         sda_prev_q   <= 1'b1;
         settle_q     <= 3'b000;
         state_q      <= IDLE;
         bit_cnt_q    <= 4'd0;
         shift_q      <= 8'h00;
         tx_q         <= 8'h00;
         rw_q         <= 1'b0;
         sda_oe_q     <= 1'b0;
         reg_addr_q   <= 8'h00;
         reg_wrdata_q <= 8'h00;
         reg_wr_q     <= 1'b0;
         reg_rd_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         scl_meta_q   <= scl_meta_d;
         scl_sync_q   <= scl_sync_d;
         scl_prev_q   <= scl_prev_d;
         sda_meta_q   <= sda_meta_d;
         sda_sync_q   <= sda_sync_d;
         sda_prev_q   <= sda_prev_d;
         settle_q     <= settle_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         rw_q         <= rw_d;
         sda_oe_q     <= sda_oe_d;
         reg_addr_q   <= reg_addr_d;
         reg_wrdata_q <= reg_wrdata_d;
         reg_wr_q     <= reg_wr_d;
         reg_rd_q     <= reg_rd_d;
         busy_q       <= busy_d;
      end
   end

   assign i2c_sdat   = sda_oe_q ? 1'b0 : 1'bz;
   assign reg_addr   = reg_addr_q;
   assign reg_wrdata = reg_wrdata_q;
   assign reg_wr     = reg_wr_q;
   assign reg_rd     = reg_rd_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-banged I2C master, register-file responder,
// reference pointer/memory model and a strobe scoreboard.
module tb_i2c_slave_regif;
   localparam int Q = 6;   // quarter SCL period in Clk cycles (SCL = Clk/24)

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } ev_t;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   logic       in_cond = 1'b0;
   wire        sda_bus;
   logic [7:0] reg_addr, reg_wrdata;
   logic [7:0] reg_rddata = 8'h00;
   logic       reg_wr, reg_rd, busy;

   int         checks = 0;
   int         errors = 0;
   int         sda_viol = 0;
   ev_t        exp_q[$];
   logic [7:0] wbuf[$];
   logic [7:0] ref_mem[256];
   logic [7:0] dev_mem[256];
   logic [7:0] ref_ptr = 8'h00;

   always #5 Clk = ~Clk;

   pullup (sda_bus);
   assign sda_bus = m_low ? 1'b0 : 1'bz;

   i2c_slave_regif #(.DEV_ADDR(7'h10)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .i2c_sclk(scl), .i2c_sdat(sda_bus),
      .reg_addr(reg_addr), .reg_wrdata(reg_wrdata), .reg_wr(reg_wr),
      .reg_rd(reg_rd), .reg_rddata(reg_rddata), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Register-file responder: data valid only in the cycle after reg_rd.
   initial begin
      forever begin
         @(negedge Clk);
         if (reg_rd) reg_rddata = dev_mem[reg_addr];
         else        reg_rddata = 8'($urandom);
         if (reg_wr) dev_mem[reg_addr] = reg_wrdata;
      end
   end

   // Scoreboard monitor: every strobe must match the next expected event.
   initial begin
      ev_t e;
      forever begin
         @(negedge Clk);
         if (reg_wr || reg_rd) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=0x%0h required none", reg_wr, reg_rd, reg_addr);
            end else begin
               e = exp_q.pop_front();
               check("strobe_kind", {30'd0, reg_wr, reg_rd}, {30'd0, e.wr, ~e.wr});
               check("strobe_addr", reg_addr, e.addr);
               if (e.wr) check("wr_data", reg_wrdata, e.data);
            end
         end
      end
   end

   // SDA must hold while SCL is high unless the master is making START/STOP.
   initial begin
      logic scl_d1, sda_d1;
      scl_d1 = 1'b1;
      sda_d1 = 1'b1;
      forever begin
         @(negedge Clk);
         if (scl && scl_d1 && !in_cond && sda_bus !== sda_d1) sda_viol++;
         scl_d1 = scl;
         sda_d1 = sda_bus;
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #2;
   endtask

   task automatic m_start();
      in_cond = 1'b1;
      m_low = 1'b0; tick(Q);
      scl = 1'b1;   tick(2*Q);
      m_low = 1'b1; tick(2*Q);
      scl = 1'b0;   tick(Q);
      in_cond = 1'b0;
   endtask

   task automatic m_stop();
      in_cond = 1'b1;
      m_low = 1'b1; tick(Q);
      scl = 1'b1;   tick(2*Q);
      m_low = 1'b0; tick(2*Q);
      in_cond = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      m_low = ~b; tick(Q);
      scl = 1'b1; tick(2*Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic recv_bit(output logic b);
      m_low = 1'b0; tick(Q);
      scl = 1'b1;   tick(Q);
      b = sda_bus;  tick(Q);
      scl = 1'b0;   tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack_n);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      recv_bit(ack_n);
   endtask

   task automatic read_byte(output logic [7:0] b, input logic ack);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(x);
         b[i] = x;
      end
      send_bit(~ack);
   endtask

   // Write transaction: pointer byte followed by the bytes in wbuf.
   task automatic do_write(input logic [7:0] ptr);
      logic a;
      ev_t  e;
      m_start();
      write_byte(8'h20, a);
      check("addr_ack_w", a, 0);
      check("busy_addressed", busy, 1);
      write_byte(ptr, a);
      check("ptr_ack", a, 0);
      ref_ptr = ptr;
      foreach (wbuf[i]) begin
         e = '{wr: 1'b1, addr: ref_ptr, data: wbuf[i]};
         exp_q.push_back(e);
         ref_mem[ref_ptr] = wbuf[i];
         ref_ptr = ref_ptr + 8'd1;
         write_byte(wbuf[i], a);
         check("data_ack", a, 0);
      end
      m_stop();
      check("busy_after_stop", busy, 0);
   endtask

   // Read n bytes, optionally setting the pointer first with a repeated START.
   task automatic do_read(input int n, input bit set_ptr, input logic [7:0] ptr);
      logic       a;
      logic [7:0] b;
      logic [7:0] p;
      ev_t        e;
      m_start();
      if (set_ptr) begin
         write_byte(8'h20, a);
         check("addr_ack_w", a, 0);
         write_byte(ptr, a);
         check("ptr_ack", a, 0);
         ref_ptr = ptr;
         m_start();
      end
      p = ref_ptr;
      e = '{wr: 1'b0, addr: p, data: 8'h00};
      exp_q.push_back(e);
      write_byte(8'h21, a);
      check("addr_ack_r", a, 0);
      for (int i = 0; i < n; i++) begin
         if (i != n - 1) begin
            e = '{wr: 1'b0, addr: p + 8'(i + 1), data: 8'h00};
            exp_q.push_back(e);
         end
         read_byte(b, i != n - 1);
         check("rd_data", b, ref_mem[p + 8'(i)]);
      end
      ref_ptr = p + 8'(n);
      check("sda_released_after_nack", sda_bus, 1);
      check("busy_after_nack", busy, 0);
      m_stop();
   endtask

   task automatic do_wrong(input logic [6:0] adr, input logic rw, input logic [7:0] junk);
      logic a;
      m_start();
      write_byte({adr, rw}, a);
      check("wrong_addr_nack", a, 1);
      check("busy_wrong_addr", busy, 0);
      write_byte(junk, a);
      check("ignored_byte_nack", a, 1);
      m_stop();
   endtask

   initial begin
      logic       a;
      logic [7:0] v;
      logic [6:0] wa;
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         ref_mem[i] = v;
         dev_mem[i] = v;
      end
      ref_mem[8'h10] = 8'h3C; dev_mem[8'h10] = 8'h3C;
      ref_mem[8'h11] = 8'hC3; dev_mem[8'h11] = 8'hC3;

      tick(5);
      check("rst_reg_addr", reg_addr, 0);
      check("rst_reg_wrdata", reg_wrdata, 0);
      check("rst_reg_wr", reg_wr, 0);
      check("rst_reg_rd", reg_rd, 0);
      check("rst_busy", busy, 0);
      check("rst_sda_released", sda_bus, 1);
      Rst_n = 1'b1;
      tick(5);

      wbuf = '{8'hA5, 8'h5A};
      do_write(8'h05);
      do_read(2, 1'b1, 8'h10);
      do_wrong(7'h11, 1'b0, 8'h05);
      wbuf = '{8'($urandom), 8'($urandom)};
      do_write(8'hFF);

      // Reset in the middle of a data byte.
      m_start();
      write_byte(8'h20, a);
      check("addr_ack_w", a, 0);
      write_byte(8'h40, a);
      check("ptr_ack", a, 0);
      for (int i = 7; i >= 4; i--) send_bit(v[i]);
      Rst_n = 1'b0;
      #1;
      check("midrst_reg_addr", reg_addr, 0);
      check("midrst_reg_wr", reg_wr, 0);
      check("midrst_reg_rd", reg_rd, 0);
      check("midrst_busy", busy, 0);
      ref_ptr = 8'h00;
      tick(3);
      Rst_n = 1'b1;
      for (int i = 3; i >= 0; i--) send_bit(v[i]);
      recv_bit(a);
      check("after_rst_no_ack", a, 1);
      m_stop();
      wbuf = '{8'($urandom), 8'($urandom), 8'($urandom)};
      do_write(8'($urandom));

      for (int t = 0; t < 16; t++) begin
         case ($urandom_range(0, 4))
            0, 1: begin
               wbuf.delete();
               for (int k = 0; k < int'($urandom_range(1, 4)); k++) wbuf.push_back(8'($urandom));
               do_write(8'($urandom_range(0, 255)));
            end
            2: do_read(int'($urandom_range(1, 3)), 1'b1, 8'($urandom));
            3: do_read(int'($urandom_range(1, 3)), 1'b0, 8'h00);
            default: begin
               wa = 7'($urandom);
               if (wa == 7'h10) wa = 7'h11;
               do_wrong(wa, 1'($urandom), 8'($urandom));
            end
         endcase
      end

      tick(20);
      check("scoreboard_empty", exp_q.size(), 0);
      check("sda_stable_while_scl_high", sda_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regif.md
I2C_SLAVE_REGIF -- requirements
Module: i2c_slave_regif

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h10, the 7-bit target address this block answers to.
REQ-002 SHALL have port Clk, input, 1 bit, system clock; Clk frequency is at least 20x the SCL frequency.
REQ-003 SHALL have port Rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port i2c_sclk, input, 1 bit, I2C clock from the bus master.
REQ-005 SHALL have port i2c_sdat, inout, 1 bit, I2C data; driven only to 0 or Z, never to 1.
REQ-006 SHALL have port reg_addr, output, 8 bits, current register pointer.
REQ-007 SHALL have port reg_wrdata, output, 8 bits, write data; valid while reg_wr is high.
REQ-008 SHALL have port reg_wr, output, 1 bit, one-Clk write strobe.
REQ-009 SHALL have port reg_rd, output, 1 bit, one-Clk read strobe.
REQ-010 SHALL have port reg_rddata, input, 8 bits, read data; sampled exactly 1 Clk after reg_rd.
REQ-011 SHALL have port busy, output, 1 bit, high from an addressed START until the next STOP, NACK or mismatch.

Function
REQ-012 SHALL pass SCL and SDA through 2-FF synchronizers; all edge and condition detection uses the synchronized signals only.
REQ-013 SHALL detect START as a synchronized SDA falling edge while SCL is high.
REQ-014 SHALL detect STOP as a synchronized SDA rising edge while SCL is high.
REQ-015 SHALL sample incoming bits, MSB first, on the synchronized SCL rising edge.
REQ-016 SHALL change its SDA drive only on the Clk after a synchronized SCL falling edge.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK.
REQ-018 SHALL go to ADDR from any state on START, including a repeated START, and clear the bit counter.
REQ-019 SHALL go to IDLE from any state on STOP and release SDA.
REQ-020 ADDR: after 8 bits, SHALL go to ADDR_ACK if bits[7:1]==DEV_ADDR; otherwise SHALL go to IDLE with no ACK and ignore the bus until the next START.
REQ-021 All ACK states SHALL drive SDA low from the SCL falling edge after bit 8 until the SCL falling edge after bit 9.
REQ-022 After ADDR_ACK, R/W=0 SHALL go to PTR and R/W=1 SHALL go to RDATA.
REQ-023 PTR: the received byte SHALL load reg_addr; then ACK and go to WDATA.
REQ-024 WDATA: after 8 bits, SHALL set reg_wrdata, pulse reg_wr one Clk with the current reg_addr, ACK, then increment reg_addr.
REQ-025 reg_addr SHALL increment modulo 256 (8'hFF wraps to 8'h00) after each written or read byte; the pointer persists across transactions.
REQ-026 On entry to RDATA, SHALL pulse reg_rd with the current reg_addr, latch reg_rddata 1 Clk later, and drive bit 7 at the falling edge that ends the ACK.
REQ-027 RDATA: each 0 bit SHALL drive SDA low and each 1 bit SHALL release SDA; after 8 bits, SHALL release SDA, go to MACK, and increment reg_addr.
REQ-028 MACK: on sampled SDA=0 (master ACK), SHALL go to RDATA for the next byte; on SDA=1 (NACK), SHALL go to IDLE with SDA released.
REQ-029 SHALL never drive SDA low while SCL is high, except while holding an ACK bit or data bit already driven.

Reset
REQ-030 On Rst_n low, SHALL immediately set state=IDLE, SDA released, reg_addr=0, reg_wrdata=0, reg_wr=0, reg_rd=0, busy=0, and bit counter=0.
REQ-031 Reset during a transfer SHALL abort it with no further strobes; after release, SHALL ignore the bus until the next START.

Verification
REQ-032 START, 0x20, 0x05, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg_wr at addr 0x05 with data 0xA5, then addr 0x06 with data 0x5A; busy falls on STOP.
REQ-033 START, 0x20, 0x10, Sr, 0x21, read 2 bytes (ACK then NACK), STOP, with reg_rddata=0x3C then 0xC3 -> reg_rd at 0x10 and 0x11; bus carries 0x3C then 0xC3; SDA released after the NACK.
REQ-034 START, 0x22 (wrong address), 0x05, STOP -> no ACK (SDA stays high at bit 9); no reg_wr or reg_rd; busy stays 0.
REQ-035 Write with pointer 0xFF and 2 data bytes -> writes land at addr 0xFF then 0x00.
REQ-036 Rst_n asserted mid data byte -> all outputs at reset values within 0 Clk; next full write transaction works normally.
REQ-037 Every test -> no SDA transition while SCL is high, except START/STOP generated by the master.
